rr_priority_arbiter: RTL
========================

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter N, default 8, number of requesters; legal range 2..32.
REQ-002 The block SHALL have derived parameter W, default $clog2(N), grant index width.
Ports:
REQ-003 The block SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port request  input  N  one bit per requester; bit i high = requester i pending.
REQ-006 The block SHALL have port mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 The block SHALL have port lock  input  1  at acceptance, regrant the same requester if it still requests.
REQ-008 The block SHALL have port gnt_ready  input  1  consumer accepts the current grant.
REQ-009 The block SHALL have port gnt_valid  output  1  registered; a grant is presented.
REQ-010 The block SHALL have port grant  output  W  registered; index of the granted requester.
REQ-011 The block SHALL have port grant_onehot  output  N  registered; one-hot form of grant, 0 when gnt_valid=0.
REQ-012 The block SHALL have port valid  output  1  combinational OR-reduction of request.

Function
REQ-013 The block SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-014 IDLE: if request!=0 at a rising edge, the block SHALL enter GRANT at that edge with the arbitration winner; latency request->gnt_valid = 1 cycle.
REQ-015 IDLE with request==0 SHALL remain IDLE, outputs held at 0.
REQ-016 Fixed mode SHALL select the highest set index of request.
REQ-017 Round-robin mode SHALL search from (last+1) mod N upward, wrapping, selecting the first set bit; last = most recently accepted index.
REQ-018 GRANT: while gnt_ready=0, grant, grant_onehot, gnt_valid SHALL hold stable regardless of request, mode or lock changes.
REQ-019 Acceptance = gnt_valid & gnt_ready at a rising edge.
REQ-020 On acceptance with lock=1 and request[grant]=1, the block SHALL stay in GRANT with the same index and SHALL NOT update last.
REQ-021 On acceptance otherwise, the block SHALL set last=grant and rearbitrate in the same edge using the current request and the updated last; if the result is nonzero, stay in GRANT with the new winner (back-to-back, no bubble), else go to IDLE.
REQ-022 A mode change SHALL take effect only at the next arbitration, never on a held grant.
REQ-023 Withdrawal of request[grant] before acceptance SHALL NOT cancel the grant.
REQ-024 grant_onehot SHALL always equal (1<<grant) when gnt_valid=1.
REQ-025 grant SHALL never exceed N-1 for non-power-of-two N.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, gnt_valid=0, grant=0, grant_onehot=0, last=N-1, independent of clk.
REQ-027 After reset the first round-robin search SHALL start at index 0.
REQ-028 Reset asserted mid-GRANT SHALL discard the pending grant without an acceptance.

Verification (N=8)
REQ-029 Reset: rst_n=0, request=8'hFF -> gnt_valid=0, grant=0, grant_onehot=0, valid=1; release with request=0 -> gnt_valid stays 0.
REQ-030 Fixed: mode=0, request=8'b10101010, gnt_ready=1 -> one cycle later grant=7, grant_onehot=8'h80, regranted 7 each cycle.
REQ-031 Round-robin: mode=1, request=8'hFF, gnt_ready=1 held -> grant sequence 0,1,2,...,7,0 on consecutive cycles, no bubbles.
REQ-032 Backpressure: grant=3 presented, gnt_ready=0 for 3 cycles while request changes to 8'h01 -> grant stays 3, gnt_valid stays 1; then ready=1 -> next grant=0.
REQ-033 Lock: mode=1, request=8'h06, lock=1 at acceptance of grant=1 -> grant=1 again; lock=0 at next acceptance -> grant=2.
REQ-034 Async reset mid-grant: rst_n pulsed low between clock edges while gnt_valid=1 -> outputs clear before next edge; mode=1, request=8'h81 afterwards -> grant=0.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// Fixed-priority / round-robin arbiter with registered grant, lock and back-to-back regrant.
// Latency: request to gnt_valid is 1 cycle; acceptance re-arbitrates in the same edge with no bubble.
// Backpressure: grant is held stable while gnt_ready is low; valid is combinational |request.
module rr_priority_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] request,
  input  logic         mode,
  input  logic         lock,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] grant,
  output logic [N-1:0] grant_onehot,
  output logic         valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] grant_q, grant_d, last_q, last_d, base, winner;
  logic [N-1:0] onehot_q, onehot_d, above, masked;
  logic         accept, hold_lock;

  assign valid     = |request;
  assign accept    = (state_q == GRANT) && gnt_ready;
  assign hold_lock = lock && request[grant_q];

  // On acceptance the just-accepted index becomes the new round-robin pointer.
  assign base = accept ? grant_q : last_q;

  always_comb begin
    winner = '0;
    above  = '0;
    for (int i = 0; i < N; i++) above[i] = (i > int'(base));
    masked = request & above;
    if (!mode) begin
      for (int i = 0; i < N; i++) if (request[i]) winner = W'(i);
    end else if (|masked) begin
      for (int i = N - 1; i >= 0; i--) if (masked[i]) winner = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--) if (request[i]) winner = W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    onehot_d = onehot_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d  = GRANT;
          grant_d  = winner;
          onehot_d = {{(N-1){1'b0}}, 1'b1} << winner;
        end
      end
      GRANT: begin
        if (accept && !hold_lock) begin
          last_d = grant_q;
          if (valid) begin
            grant_d  = winner;
            onehot_d = {{(N-1){1'b0}}, 1'b1} << winner;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      onehot_q <= '0;
      last_q   <= W'(N - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      onehot_q <= onehot_d;
      last_q   <= last_d;
    end
  end

  assign gnt_valid    = (state_q == GRANT);
  assign grant        = grant_q;
  assign grant_onehot = onehot_q;

endmodule
